// File: rtl/vmem_tcm_responder.sv
// Responder for the vector-core memory interface, backed by a local TCM array.
// Every grant produces exactly one response after a fixed LATENCY, in grant order.
module vmem_tcm_responder #(
  parameter int unsigned VMEM_W    = 128,
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                vmem_req_i,
  output logic                vmem_gnt_o,
  input  logic [31:0]         vmem_addr_i,
  input  logic                vmem_we_i,
  input  logic [VMEM_W/8-1:0] vmem_be_i,
  input  logic [VMEM_W-1:0]   vmem_wdata_i,
  output logic                vmem_rvalid_o,
  output logic [VMEM_W-1:0]   vmem_rdata_o,
  output logic                vmem_err_o,
  input  logic                stall_i,
  output logic                busy_o,
  output logic [15:0]         err_count_o
);

  localparam int unsigned BYTES = VMEM_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned DEPTH = MEM_BYTES / BYTES;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // 33-bit bounds so BASE_ADDR + MEM_BYTES cannot wrap at the top of the map.
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(MEM_BYTES);

  logic [VMEM_W-1:0] mem_q [DEPTH];

  logic [LATENCY-1:0] pipe_v;
  logic [LATENCY-1:0] pipe_e;
  logic [VMEM_W-1:0]  pipe_d [LATENCY];
  logic [15:0]        err_cnt_q;

  logic [32:0]      addr_ext;
  logic             xfer;
  logic             legal;
  logic [IDX_W-1:0] idx;

  assign vmem_gnt_o = vmem_req_i & ~stall_i & ~rst_i;
  assign xfer       = vmem_req_i & vmem_gnt_o;

  assign addr_ext = {1'b0, vmem_addr_i};
  assign legal    = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT) &&
                    (vmem_addr_i[OFF_W-1:0] == '0);
  // BASE_ADDR is aligned to MEM_BYTES, so the word index is a plain slice.
  assign idx      = vmem_addr_i[OFF_W +: IDX_W];

  always_ff @(posedge clk_i) begin
    if (xfer && legal && vmem_we_i) begin
      for (int i = 0; i < BYTES; i++) begin
        if (vmem_be_i[i]) mem_q[idx][i*8 +: 8] <= vmem_wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_v    <= '0;
      pipe_e    <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= xfer;
      pipe_e[0] <= xfer & ~legal;
      pipe_d[0] <= (xfer && legal && !vmem_we_i) ? mem_q[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (xfer && !legal && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign vmem_rvalid_o = pipe_v[LATENCY-1];
  assign vmem_err_o    = pipe_e[LATENCY-1];
  assign vmem_rdata_o  = pipe_d[LATENCY-1];
  assign busy_o        = |pipe_v;
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_vmem_tcm_responder.sv
// Scoreboard bench for vmem_tcm_responder: expected responses are queued at grant
// time from a reference model and checked (value and arrival cycle) on rvalid.
module tb_vmem_tcm_responder;

  localparam int LATENCY = 2;
  localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic         stall = 1'b0;
  logic [31:0]  addr = '0;
  logic [15:0]  be = '0;
  logic [127:0] wdata = '0;
  logic         gnt, rvalid, err, busy;
  logic [127:0] rdata;
  logic [15:0]  err_count;

  vmem_tcm_responder #(
    .VMEM_W(128), .MEM_BYTES(65536), .BASE_ADDR(32'h8000_0000), .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .vmem_req_i(req), .vmem_gnt_o(gnt), .vmem_addr_i(addr), .vmem_we_i(we),
    .vmem_be_i(be), .vmem_wdata_i(wdata),
    .vmem_rvalid_o(rvalid), .vmem_rdata_o(rdata), .vmem_err_o(err),
    .stall_i(stall), .busy_o(busy), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [int];
  int           checks = 0;
  int           failures = 0;

  function automatic bit tb_legal(input logic [31:0] a);
    logic [32:0] ae;
    ae = {1'b0, a};
    return (ae >= 33'h0_8000_0000) && (ae < 33'h0_8001_0000) && (a[3:0] == 4'h0);
  endfunction

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rvalid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid: cycle=%0d rdata=%h err=%b required=no response", cyc, rdata, err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (err !== e.err || rdata !== e.data || cyc !== e.due) begin
            failures++;
            $display("FAIL response: err=%b rdata=%h cycle=%0d required err=%b rdata=%h cycle=%0d",
                     err, rdata, cyc, e.err, e.data, e.due);
          end
        end
      end else begin
        checks++;
        if (rvalid !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs: rvalid=%b rdata=%h err=%b required 0/0/0", rvalid, rdata, err);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] b,
                       input logic [127:0] d, input int stall_cycles);
    exp_t         e;
    bit           granted;
    int           idx;
    logic [127:0] cur;
    granted = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int k = 0; k < 10; k++) begin
      stall = (k < stall_cycles);
      #1;
      checks++;
      if (gnt !== ~stall) begin
        failures++;
        $display("FAIL gnt_vs_stall: gnt=%b required=%b addr=%h", gnt, ~stall, a);
      end
      if (gnt === 1'b1) begin
        granted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) begin
      failures++;
      $display("FAIL grant_timeout: gnt=%b required=1 addr=%h", gnt, a);
      req = 1'b0;
      stall = 1'b0;
      return;
    end
    e.due = cyc + LATENCY;
    idx = int'((a - 32'h8000_0000) >> 4);
    if (!tb_legal(a)) begin
      e.err = 1'b1; e.data = '0;
    end else if (w) begin
      e.err = 1'b0; e.data = '0;
      cur = model.exists(idx) ? model[idx] : '0;
      for (int i = 0; i < 16; i++) if (b[i]) cur[i*8 +: 8] = d[i*8 +: 8];
      model[idx] = cur;
    end else begin
      e.err = 1'b0;
      e.data = model.exists(idx) ? model[idx] : 'x;
    end
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    req = 1'b0; stall = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_timeout: pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        err_count !== 16'h0 || rdata !== '0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b rvalid=%b err=%b busy=%b err_count=%h rdata=%h required all 0",
               gnt, rvalid, err, busy, err_count, rdata);
    end
    rst = 1'b0; req = 1'b0;
  endtask

  task automatic test_write_read();
    issue(1'b1, 32'h8000_0010, 16'hFFFF, PAT, 0);
    issue(1'b0, 32'h8000_0010, 16'h0000, '0, 0);
    drain("write_read");
  endtask

  task automatic test_partial_write();
    issue(1'b1, 32'h8000_0020, 16'hFFFF, {128{1'b1}}, 0);
    issue(1'b1, 32'h8000_0020, 16'h000F, {96'h5555_5555_5555_5555_5555_5555, 32'hDEADBEEF}, 0);
    issue(1'b0, 32'h8000_0020, 16'h0000, '0, 0);
    issue(1'b1, 32'h8000_0030, 16'hFFFF, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
    issue(1'b1, 32'h8000_0030, 16'h0000, 128'h0, 0);
    issue(1'b0, 32'h8000_0030, 16'h0000, '0, 0);
    issue(1'b1, 32'h8000_FFF0, 16'hF00F, 128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 0);
    issue(1'b0, 32'h8000_FFF0, 16'h0000, '0, 0);
    drain("partial_write");
  endtask

  task automatic test_illegal();
    issue(1'b0, 32'h7FFF_FFF0, 16'h0, '0, 0);
    issue(1'b0, 32'h8001_0000, 16'h0, '0, 0);
    issue(1'b0, 32'h8000_0004, 16'h0, '0, 0);
    drain("illegal");
    checks++;
    if (err_count !== 16'd3) begin
      failures++;
      $display("FAIL illegal_err_count: err_count=%0d required=3", err_count);
    end
    issue(1'b1, 32'h8000_0011, 16'hFFFF, 128'h0, 0);
    issue(1'b0, 32'h8000_0010, 16'h0, '0, 0);
    drain("illegal_write");
    checks++;
    if (err_count !== 16'd4) begin
      failures++;
      $display("FAIL illegal_write_err_count: err_count=%0d required=4", err_count);
    end
  endtask

  task automatic test_stall_reset();
    issue(1'b0, 32'h8000_0010, 16'h0, '0, 0);
    issue(1'b0, 32'h8000_0020, 16'h0, '0, 1);
    issue(1'b0, 32'h8000_0030, 16'h0, '0, 0);
    issue(1'b0, 32'h8000_FFF0, 16'h0, '0, 0);
    drain("stall");
    issue(1'b0, 32'h8000_0010, 16'h0, '0, 0);
    issue(1'b0, 32'h8000_0020, 16'h0, '0, 0);
    @(negedge clk);
    #1;
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_reset: busy=%b required=1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || busy !== 1'b0 || err_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_flush: rvalid=%b busy=%b err_count=%h required 0/0/0", rvalid, busy, err_count);
    end
    sb.delete();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_busy: busy=%b required=0", busy);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 65540; n++) issue(1'b0, 32'h7FFF_FFF0, 16'h0, '0, 0);
    drain("saturation");
    checks++;
    if (err_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL err_count_saturation: err_count=%h required=ffff", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_illegal();
    test_stall_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
